imem_loader: RTL

Instruction-memory programmer for the 3-stage pipeline. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words and drives the instruction memory's write port at word-aligned byte addresses starting at 0. While a load is in progress it holds the core so that no fetch observes a partially written program.

---
 rtl/imem_loader.sv | 94 +++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit words
// and writes them from address 0 while holding the core.
module imem_loader #(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        core_hold,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam logic [7:0] LP_DEPTH = 8'(DEPTH);

    logic [2:0]  r_state;
    logic [7:0]  r_count;
    logic [7:0]  r_word_idx;
    logic [1:0]  r_lane;
    logic [31:0] r_asm;
    logic        w_xfer;

    assign w_xfer = byte_valid && byte_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_word_idx <= '0;
            r_lane     <= '0;
            r_asm      <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_ERR: begin
                    if (start) r_state <= S_COUNT;
                end
                S_COUNT: begin
                    if (w_xfer) begin
                        r_count <= byte_data;
                        if (byte_data == 8'd0) begin
                            r_state <= S_DONE;
                        end else if (byte_data > LP_DEPTH) begin
                            r_state <= S_ERR;
                        end else begin
                            r_word_idx <= '0;
                            r_lane     <= '0;
                            r_state    <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_asm[{r_lane, 3'b000} +: 8] <= byte_data;
                        r_lane <= r_lane + 2'd1;
                        if (r_lane == 2'd3) r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // Index advances on the edge that ends the write, so the address stays stable during it.
                    r_word_idx <= r_word_idx + 8'd1;
                    if (r_word_idx + 8'd1 == r_count) r_state <= S_DONE;
                    else                              r_state <= S_DATA;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        byte_ready = (r_state == S_COUNT) || (r_state == S_DATA);
        imem_we    = (r_state == S_WRITE);
        imem_waddr = {22'd0, r_word_idx, 2'b00};
        imem_wdata = r_asm;
        core_hold  = (r_state == S_COUNT) || (r_state == S_DATA) ||
                     (r_state == S_WRITE) || (r_state == S_ERR);
        done       = (r_state == S_DONE);
        err        = (r_state == S_ERR);
    end

endmodule
